// File: rtl/feistel_encrypt_if.sv
// Request/response bundle for the Feistel cipher block.
// master: requester side, slave: cipher side.
interface feistel_encrypt_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] number;
    logic [W-1:0] key;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] enc_number;
    logic         busy;

    modport master (
        output in_valid, number, key, mode, out_ready,
        input  in_ready, out_valid, enc_number, busy
    );

    modport slave (
        input  in_valid, number, key, mode, out_ready,
        output in_ready, out_valid, enc_number, busy
    );
endinterface

// File: rtl/feistel_encrypt.sv
// Iterative Feistel cipher: one round per clock, encrypt or decrypt.
// Decrypt reuses the same round datapath with the round keys applied in
// reverse order; the final {R,L} output swap makes the two directions inverse.
module feistel_encrypt #(
    parameter int unsigned W      = 8,
    parameter int unsigned ROUNDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    feistel_encrypt_if.slave  bus
);
    localparam int unsigned H  = W / 2;
    localparam int unsigned CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    logic [H-1:0]    r_l;
    logic [H-1:0]    r_r;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_key;
    logic            r_mode;
    logic [W-1:0]    r_enc;
    logic            r_out_valid;
    logic            r_busy;

    int unsigned     w_idx;
    logic [W-1:0]    w_key_r;
    logic [H-1:0]    w_f;
    logic [H-1:0]    w_new_r;
    logic            w_last;

    // Rotate a W-bit word left by s (s < W).
    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int unsigned s);
        logic [2*W-1:0] t;
        t = {v, v} << s;
        return t[2*W-1:W];
    endfunction

    // Round function: expand R, mix with the round key, fold the halves.
    function automatic logic [H-1:0] round_f(input logic [H-1:0] r, input logic [W-1:0] k);
        logic [W-1:0] e;
        logic [W-1:0] x;
        e = {r[H-2:0], r[H-1], r};
        x = e ^ k;
        return x[W-1:H] + x[H-1:0] + {{(H-1){1'b0}}, k[0]};
    endfunction

    // Round key selection and one round of the datapath.
    always_comb begin
        w_idx   = r_mode ? (ROUNDS - 1 - 32'(r_cnt)) : 32'(r_cnt);
        w_key_r = rotl(r_key, w_idx % W);
        w_f     = round_f(r_r, w_key_r);
        w_new_r = r_l ^ w_f;
        w_last  = (32'(r_cnt) == ROUNDS - 1);
    end

    // Control FSM with registered outputs and round state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_l         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_key       <= '0;
            r_mode      <= 1'b0;
            r_enc       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_l     <= bus.number[W-1:H];
                        r_r     <= bus.number[H-1:0];
                        r_key   <= bus.key;
                        r_mode  <= bus.mode;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_l   <= r_r;
                    r_r   <= w_new_r;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_enc       <= {w_new_r, r_r};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // in_ready is combinational so it is low during reset and high right after.
    assign bus.in_ready   = (r_state == IDLE) && !reset;
    assign bus.out_valid  = r_out_valid;
    assign bus.enc_number = r_enc;
    assign bus.busy       = r_busy;
endmodule
